// File: rtl/instr_fetch_arbiter.sv
// Round-robin arbiter sharing one registered instruction memory port among NUM_REQ
// fetch requesters, one transaction in flight, with a timeout that substitutes NO_OP.
module instr_fetch_arbiter #(
    parameter int          NUM_REQ = 2,
    parameter logic [31:0] NO_OP   = 32'h00000013,
    parameter int          TIMEOUT = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_REQ-1:0]    req_i,
    input  logic [NUM_REQ*32-1:0] addr_i,
    output logic [NUM_REQ-1:0]    gnt_o,
    output logic [NUM_REQ-1:0]    rvalid_o,
    output logic [31:0]           rdata_o,
    output logic                  err_o,
    output logic                  mem_req_o,
    output logic [31:0]           mem_addr_o,
    output logic                  mem_enable_o,
    input  logic                  mem_gnt_i,
    input  logic [31:0]           mem_rdata_i
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t             state_reg,   state_next;
    logic [PTR_W-1:0]   rr_ptr_reg,  rr_ptr_next;
    logic [PTR_W-1:0]   owner_reg,   owner_next;
    logic [31:0]        addr_reg,    addr_next;
    logic               mem_req_reg, mem_req_next;
    logic [3:0]         cnt_reg,     cnt_next;

    logic [31:0]        addr_arr [NUM_REQ];
    logic               win_found;
    logic [PTR_W-1:0]   win_idx;
    logic               resp_fire;
    logic               resp_timeout;
    logic               resp_live;

    // Index base+off reduced modulo NUM_REQ (off < NUM_REQ, so one subtraction suffices).
    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return sum[PTR_W-1:0];
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign addr_arr[gi] = addr_i[32*gi +: 32];
            // A requester that withdrew before the response gets no grant.
            assign gnt_o[gi]    = resp_live && (owner_reg == PTR_W'(gi)) && req_i[gi];
            assign rvalid_o[gi] = gnt_o[gi];
        end
    endgenerate

    // Scan from the far end back toward rr_ptr so the closest requester is written last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            if (req_i[wrap_idx(rr_ptr_reg, off)]) begin
                win_found = 1'b1;
                win_idx   = wrap_idx(rr_ptr_reg, off);
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        rr_ptr_next  = rr_ptr_reg;
        owner_next   = owner_reg;
        addr_next    = addr_reg;
        mem_req_next = 1'b0;
        cnt_next     = cnt_reg;
        resp_fire    = 1'b0;
        resp_timeout = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (win_found) begin
                    owner_next   = win_idx;
                    addr_next    = addr_arr[win_idx];
                    mem_req_next = 1'b1;
                    state_next   = ISSUE;
                end
            end
            ISSUE: begin
                cnt_next   = '0;
                state_next = RESP;
            end
            RESP: begin
                if (mem_gnt_i) begin
                    resp_fire   = 1'b1;
                    rr_ptr_next = wrap_idx(owner_reg, 1);
                    state_next  = IDLE;
                end else if (cnt_reg == 4'(TIMEOUT)) begin
                    resp_fire    = 1'b1;
                    resp_timeout = 1'b1;
                    rr_ptr_next  = wrap_idx(owner_reg, 1);
                    state_next   = IDLE;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg   <= IDLE;
            rr_ptr_reg  <= '0;
            owner_reg   <= '0;
            addr_reg    <= '0;
            mem_req_reg <= 1'b0;
            cnt_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            rr_ptr_reg  <= rr_ptr_next;
            owner_reg   <= owner_next;
            addr_reg    <= addr_next;
            mem_req_reg <= mem_req_next;
            cnt_reg     <= cnt_next;
        end
    end

    // Reset in the response cycle drops the fetch silently.
    assign resp_live    = resp_fire && !rst_i;
    assign rdata_o      = (resp_live && !resp_timeout) ? mem_rdata_i : NO_OP;
    assign err_o        = resp_live && resp_timeout;
    assign mem_req_o    = mem_req_reg;
    assign mem_addr_o   = addr_reg;
    assign mem_enable_o = !rst_i;

endmodule

// File: tb/tb_instr_fetch_arbiter.sv
// Scoreboard bench for instr_fetch_arbiter: expected responses are queued when
// requests are driven and compared when grants or error pulses appear.
module tb_instr_fetch_arbiter;

    localparam int          NUM_REQ = 2;
    localparam logic [31:0] NO_OP   = 32'h00000013;
    localparam int          TIMEOUT = 4;

    logic                  clk_i = 1'b0;
    logic                  rst_i;
    logic [NUM_REQ-1:0]    req_i;
    logic [NUM_REQ*32-1:0] addr_i;
    logic [NUM_REQ-1:0]    gnt_o;
    logic [NUM_REQ-1:0]    rvalid_o;
    logic [31:0]           rdata_o;
    logic                  err_o;
    logic                  mem_req_o;
    logic [31:0]           mem_addr_o;
    logic                  mem_enable_o;
    logic                  mem_gnt_q = 1'b0;
    logic [31:0]           mem_rdata_q = 32'h0;
    logic                  mem_ready;

    logic [31:0] mem_words [256];

    typedef struct {
        int          idx;
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    int   quota [NUM_REQ];
    int   cyc;
    int   total = 0;
    int   bad   = 0;

    instr_fetch_arbiter #(
        .NUM_REQ(NUM_REQ),
        .NO_OP  (NO_OP),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (req_i),
        .addr_i      (addr_i),
        .gnt_o       (gnt_o),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .err_o       (err_o),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_enable_o(mem_enable_o),
        .mem_gnt_i   (mem_gnt_q),
        .mem_rdata_i (mem_rdata_q)
    );

    always #5 clk_i = ~clk_i;

    // One-cycle registered memory; mem_ready=0 models a memory that never answers.
    always @(posedge clk_i) begin
        mem_gnt_q   <= mem_req_o && mem_enable_o && mem_ready;
        mem_rdata_q <= mem_words[mem_addr_o[9:2]];
    end

    function automatic logic [31:0] word_at(input logic [7:0] widx);
        if (widx == 8'h20) return 32'h00500093;
        return {8'hA5, widx, 16'h0093};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic at_neg();
        exp_t e;
        @(negedge clk_i);
        if (gnt_o != '0 || err_o) begin
            if (sb_q.size() == 0) begin
                check_val("spurious_gnt", 32'(gnt_o), 32'd0);
                check_val("spurious_err", 32'(err_o), 32'd0);
            end else begin
                e = sb_q.pop_front();
                check_val("gnt",        32'(gnt_o),    32'd1 << e.idx);
                check_val("rvalid",     32'(rvalid_o), 32'd1 << e.idx);
                check_val("rdata",      rdata_o,       e.data);
                check_val("err",        32'(err_o),    32'(e.err));
                check_val("resp_cycle", 32'(cyc),      32'(e.cyc));
                $display("resp cyc=%0d gnt=%b rdata=%h err=%b", cyc, gnt_o, rdata_o, err_o);
            end
            for (int k = 0; k < NUM_REQ; k++) begin
                if (gnt_o[k] && quota[k] > 0) begin
                    quota[k]--;
                    if (quota[k] == 0) req_i[k] = 1'b0;
                end
            end
        end
    endtask

    task automatic to_next();
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic step();
        at_neg();
        to_next();
    endtask

    task automatic drain(input int bound);
        for (int i = 0; i < bound && sb_q.size() != 0; i++) step();
        check_val("drain", 32'(sb_q.size()), 32'd0);
        at_neg();
        check_val("quiet_gnt", 32'(gnt_o), 32'd0);
        check_val("quiet_err", 32'(err_o), 32'd0);
        to_next();
    endtask

    task automatic do_reset();
        rst_i     = 1'b1;
        req_i     = '0;
        addr_i    = '0;
        mem_ready = 1'b1;
        for (int k = 0; k < NUM_REQ; k++) quota[k] = 0;
        at_neg();
        check_val("en_in_rst", 32'(mem_enable_o), 32'd0);
        to_next();
        step();
        rst_i = 1'b0;
        at_neg();
        check_val("rst_gnt",     32'(gnt_o),        32'd0);
        check_val("rst_rvalid",  32'(rvalid_o),     32'd0);
        check_val("rst_err",     32'(err_o),        32'd0);
        check_val("rst_mem_req", 32'(mem_req_o),    32'd0);
        check_val("rst_addr",    mem_addr_o,        32'd0);
        check_val("rst_rdata",   rdata_o,           NO_OP);
        check_val("rst_enable",  32'(mem_enable_o), 32'd1);
        to_next();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_words[i] = word_at(8'(i));
        rst_i     = 1'b1;
        req_i     = '0;
        addr_i    = '0;
        mem_ready = 1'b1;
        cyc       = 0;
        @(posedge clk_i);
        #1;

        // Single fetch from requester 0: grant two cycles after the request.
        do_reset();
        addr_i[31:0] = 32'h80;
        req_i        = 2'b01;
        quota[0]     = 1;
        sb_q.push_back('{idx: 0, data: 32'h00500093, err: 1'b0, cyc: cyc + 2});
        at_neg();
        check_val("t1_mem_req_c0", 32'(mem_req_o), 32'd0);
        to_next();
        at_neg();
        check_val("t1_mem_req_c1", 32'(mem_req_o), 32'd1);
        check_val("t1_mem_addr",   mem_addr_o,     32'h80);
        to_next();
        drain(20);

        // Both requesting: grants alternate every three cycles with correct data.
        do_reset();
        addr_i[31:0]  = 32'h80;
        addr_i[63:32] = 32'h84;
        req_i         = 2'b11;
        quota[0]      = 2;
        quota[1]      = 2;
        sb_q.push_back('{idx: 0, data: word_at(8'h20), err: 1'b0, cyc: cyc + 2});
        sb_q.push_back('{idx: 1, data: word_at(8'h21), err: 1'b0, cyc: cyc + 5});
        sb_q.push_back('{idx: 0, data: word_at(8'h20), err: 1'b0, cyc: cyc + 8});
        sb_q.push_back('{idx: 1, data: word_at(8'h21), err: 1'b0, cyc: cyc + 11});
        drain(30);

        // Memory never grants: NO_OP with error pulse four cycles into RESP.
        do_reset();
        mem_ready    = 1'b0;
        addr_i[31:0] = 32'h88;
        req_i        = 2'b01;
        quota[0]     = 1;
        sb_q.push_back('{idx: 0, data: NO_OP, err: 1'b1, cyc: cyc + 2 + TIMEOUT});
        drain(30);
        mem_ready = 1'b1;

        // Reset lands on the response cycle; the held request is then served afresh.
        do_reset();
        addr_i[63:32] = 32'h90;
        req_i         = 2'b10;
        quota[1]      = 1;
        step();
        step();
        rst_i = 1'b1;
        at_neg();
        check_val("t4_gnt",    32'(gnt_o),        32'd0);
        check_val("t4_err",    32'(err_o),        32'd0);
        check_val("t4_enable", 32'(mem_enable_o), 32'd0);
        to_next();
        rst_i = 1'b0;
        sb_q.push_back('{idx: 1, data: word_at(8'h24), err: 1'b0, cyc: cyc + 2});
        at_neg();
        check_val("t4_mem_req", 32'(mem_req_o), 32'd0);
        check_val("t4_rdata",   rdata_o,        NO_OP);
        to_next();
        drain(20);

        // Owner withdraws during ISSUE: no grant, requester 1 wins next.
        do_reset();
        addr_i[31:0]  = 32'hA0;
        addr_i[63:32] = 32'hA4;
        req_i         = 2'b11;
        quota[1]      = 1;
        sb_q.push_back('{idx: 1, data: word_at(8'h29), err: 1'b0, cyc: cyc + 5});
        step();
        req_i[0] = 1'b0;
        step();
        at_neg();
        check_val("t5_gnt",    32'(gnt_o),    32'd0);
        check_val("t5_rvalid", 32'(rvalid_o), 32'd0);
        to_next();
        drain(20);

        // Requester 1 arrives mid-transaction and takes the next slot.
        do_reset();
        addr_i[31:0] = 32'hB0;
        req_i        = 2'b01;
        quota[0]     = 2;
        sb_q.push_back('{idx: 0, data: word_at(8'h2C), err: 1'b0, cyc: cyc + 2});
        sb_q.push_back('{idx: 1, data: word_at(8'h2D), err: 1'b0, cyc: cyc + 5});
        sb_q.push_back('{idx: 0, data: word_at(8'h2C), err: 1'b0, cyc: cyc + 8});
        step();
        addr_i[63:32] = 32'hB4;
        req_i[1]      = 1'b1;
        quota[1]      = 1;
        drain(30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
